// File: rtl/i2c_master_sequencer.sv
// Write-only I2C master transaction sequencer: START, address+W, N data bytes, STOP.
// Triggers the bit-level generators, arbitrates bus ownership and reports completion status.
module i2c_master_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int LEN_W          = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [6:0]       i_cmd_addr,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [7:0]       i_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_err,
  output logic             o_start_go,
  input  logic             i_start_done,
  output logic             o_byte_go,
  output logic [7:0]       o_byte_data,
  input  logic             i_byte_done,
  input  logic             i_byte_nack,
  output logic             o_stop_go,
  input  logic             i_stop_done,
  output logic [1:0]       o_sel
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_FETCH, S_DATA, S_STOP, S_DONE
  } state_e;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ANAK = 2'b01;
  localparam logic [1:0] ERR_DNAK = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  // The counter is compared one step early so the timeout move lands on the
  // cycle in which the count would reach TIMEOUT_CYCLES-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 2);

  state_e           state_q;
  logic [6:0]       addr_q;
  logic [LEN_W-1:0] rem_q;
  logic [1:0]       err_q;
  logic [7:0]       byte_data_q;
  logic [15:0]      cnt_q;
  logic             start_go_q;
  logic             byte_go_q;
  logic             stop_go_q;

  logic tmo;
  logic start_ok;
  logic byte_ok;
  logic stop_ok;
  logic counting;

  // A go pulse marks the first cycle of a waiting state, when done inputs are ignored.
  assign start_ok = i_start_done && !start_go_q;
  assign byte_ok  = i_byte_done  && !byte_go_q;
  assign stop_ok  = i_stop_done  && !stop_go_q;
  assign tmo      = (cnt_q == TMO_LAST);
  assign counting = (state_q == S_START) || (state_q == S_ADDR) ||
                    (state_q == S_DATA)  || (state_q == S_STOP);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      err_q       <= ERR_OK;
      byte_data_q <= '0;
      cnt_q       <= '0;
      start_go_q  <= 1'b0;
      byte_go_q   <= 1'b0;
      stop_go_q   <= 1'b0;
    end else begin
      start_go_q <= 1'b0;
      byte_go_q  <= 1'b0;
      stop_go_q  <= 1'b0;
      if (counting) begin
        cnt_q <= cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (i_cmd_valid) begin
            addr_q     <= i_cmd_addr;
            rem_q      <= i_cmd_len;
            err_q      <= ERR_OK;
            cnt_q      <= '0;
            start_go_q <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (start_ok) begin
            byte_data_q <= {addr_q, 1'b0};
            cnt_q       <= '0;
            byte_go_q   <= 1'b1;
            state_q     <= S_ADDR;
          end else if (tmo) begin
            err_q     <= ERR_TMO;
            cnt_q     <= '0;
            stop_go_q <= 1'b1;
            state_q   <= S_STOP;
          end
        end
        S_ADDR, S_DATA: begin
          if (byte_ok) begin
            cnt_q <= '0;
            if (i_byte_nack) begin
              err_q     <= (state_q == S_ADDR) ? ERR_ANAK : ERR_DNAK;
              stop_go_q <= 1'b1;
              state_q   <= S_STOP;
            end else if (rem_q == '0) begin
              stop_go_q <= 1'b1;
              state_q   <= S_STOP;
            end else begin
              state_q <= S_FETCH;
            end
          end else if (tmo) begin
            err_q     <= ERR_TMO;
            cnt_q     <= '0;
            stop_go_q <= 1'b1;
            state_q   <= S_STOP;
          end
        end
        S_FETCH: begin
          if (i_wr_valid) begin
            byte_data_q <= i_wr_data;
            if (rem_q != '0) begin
              rem_q <= rem_q - 1'b1;
            end
            cnt_q     <= '0;
            byte_go_q <= 1'b1;
            state_q   <= S_DATA;
          end
        end
        S_STOP: begin
          if (stop_ok) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else if (tmo) begin
            err_q   <= ERR_TMO;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status and bus-owner outputs decode straight from the registered state.
  always_comb begin
    o_sel = 2'b00;
    case (state_q)
      S_START:                o_sel = 2'b01;
      S_ADDR, S_FETCH, S_DATA: o_sel = 2'b10;
      S_STOP:                 o_sel = 2'b11;
      default:                o_sel = 2'b00;
    endcase
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_wr_ready  = (state_q == S_FETCH);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = err_q;
  assign o_start_go  = start_go_q;
  assign o_byte_go   = byte_go_q;
  assign o_stop_go   = stop_go_q;
  assign o_byte_data = byte_data_q;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed bench for i2c_master_sequencer: normal writes, probes, NACKs, timeouts, reset.
// Sub-block done responses are driven by hand; each scenario checks its own outputs.
module tb_i2c_master_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = '0;
  logic       busy, done;
  logic [1:0] err;
  logic       start_go, byte_go, stop_go;
  logic       start_done = 1'b0, byte_done = 1'b0, byte_nack = 1'b0, stop_done = 1'b0;
  logic [7:0] byte_data;
  logic [1:0] sel;

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  bit wr_seen = 0;
  bit done_seen = 0;

  i2c_master_sequencer #(.TIMEOUT_CYCLES(16), .LEN_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_start_go(start_go), .i_start_done(start_done),
    .o_byte_go(byte_go), .o_byte_data(byte_data),
    .i_byte_done(byte_done), .i_byte_nack(byte_nack),
    .o_stop_go(stop_go), .i_stop_done(stop_done),
    .o_sel(sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    if (wr_ready && wr_valid) accepted++;
    @(posedge clk);
    #1;
    if (wr_ready) wr_seen = 1;
    if (done) done_seen = 1;
  endtask

  task automatic accept_cmd(input logic [6:0] a, input logic [7:0] l);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Lets the first (ignored) cycle pass, then pulses the selected done input.
  task automatic respond(input int which, input bit nack);
    tick();
    case (which)
      0: start_done = 1'b1;
      1: begin byte_done = 1'b1; byte_nack = nack; end
      default: stop_done = 1'b1;
    endcase
    tick();
    start_done = 1'b0; byte_done = 1'b0; byte_nack = 1'b0; stop_done = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d);
    wr_valid = 1'b1; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got=%0b exp=0", wr_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got=%0b%0b exp=00", busy, done); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL rst_err got=%0b exp=00", err); end
    checks++; if ({start_go, byte_go, stop_go} !== 3'b000) begin errors++; $display("FAIL rst_go got=%0b exp=000", {start_go, byte_go, stop_go}); end
    checks++; if (byte_data !== 8'h00 || sel !== 2'b00) begin errors++; $display("FAIL rst_data_sel got=%0h/%0b exp=00/00", byte_data, sel); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_two();
    accepted = 0; wr_seen = 0;
    accept_cmd(7'h50, 8'd2);
    checks++; if (start_go !== 1'b1 || sel !== 2'b01) begin errors++; $display("FAIL w2_start got=%0b/%0b exp=1/01", start_go, sel); end
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL w2_busy got=%0b/%0b exp=1/0", busy, cmd_ready); end
    respond(0, 0);
    checks++; if (byte_go !== 1'b1 || byte_data !== 8'hA0 || sel !== 2'b10) begin errors++; $display("FAIL w2_addr got=%0b/%0h/%0b exp=1/a0/10", byte_go, byte_data, sel); end
    respond(1, 0);
    checks++; if (wr_ready !== 1'b1 || sel !== 2'b10) begin errors++; $display("FAIL w2_fetch got=%0b/%0b exp=1/10", wr_ready, sel); end
    feed(8'hA5);
    checks++; if (byte_go !== 1'b1 || byte_data !== 8'hA5 || wr_ready !== 1'b0) begin errors++; $display("FAIL w2_data0 got=%0b/%0h/%0b exp=1/a5/0", byte_go, byte_data, wr_ready); end
    respond(1, 0);
    feed(8'h3C);
    checks++; if (byte_go !== 1'b1 || byte_data !== 8'h3C) begin errors++; $display("FAIL w2_data1 got=%0b/%0h exp=1/3c", byte_go, byte_data); end
    wr_valid = 1'b1; wr_data = 8'h77;
    respond(1, 0);
    checks++; if (stop_go !== 1'b1 || sel !== 2'b11) begin errors++; $display("FAIL w2_stop got=%0b/%0b exp=1/11", stop_go, sel); end
    respond(2, 0);
    wr_valid = 1'b0;
    checks++; if (done !== 1'b1 || err !== 2'b00 || sel !== 2'b00) begin errors++; $display("FAIL w2_done got=%0b/%0b/%0b exp=1/00/00", done, err, sel); end
    tick();
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL w2_idle got=%0b/%0b exp=0/1", done, cmd_ready); end
    checks++; if (accepted !== 2) begin errors++; $display("FAIL w2_accepted got=%0d exp=2", accepted); end
  endtask

  task automatic test_probe();
    accepted = 0; wr_seen = 0;
    accept_cmd(7'h21, 8'd0);
    respond(0, 0);
    checks++; if (byte_data !== 8'h42) begin errors++; $display("FAIL probe_addr got=%0h exp=42", byte_data); end
    respond(1, 0);
    checks++; if (stop_go !== 1'b1 || sel !== 2'b11) begin errors++; $display("FAIL probe_stop got=%0b/%0b exp=1/11", stop_go, sel); end
    respond(2, 0);
    checks++; if (done !== 1'b1 || err !== 2'b00) begin errors++; $display("FAIL probe_done got=%0b/%0b exp=1/00", done, err); end
    tick();
    checks++; if (wr_seen !== 1'b0) begin errors++; $display("FAIL probe_wr_ready got=%0b exp=0", wr_seen); end
  endtask

  task automatic test_addr_nack();
    accepted = 0;
    accept_cmd(7'h7F, 8'd3);
    respond(0, 0);
    checks++; if (byte_data !== 8'hFE) begin errors++; $display("FAIL anak_addr got=%0h exp=fe", byte_data); end
    wr_valid = 1'b1; wr_data = 8'h99;
    respond(1, 1);
    checks++; if (stop_go !== 1'b1 || err !== 2'b01) begin errors++; $display("FAIL anak_stop got=%0b/%0b exp=1/01", stop_go, err); end
    respond(2, 0);
    checks++; if (done !== 1'b1 || err !== 2'b01) begin errors++; $display("FAIL anak_done got=%0b/%0b exp=1/01", done, err); end
    tick();
    wr_valid = 1'b0;
    checks++; if (accepted !== 0) begin errors++; $display("FAIL anak_accepted got=%0d exp=0", accepted); end
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL anak_err_hold got=%0b exp=01", err); end
  endtask

  task automatic test_data_nack();
    accepted = 0;
    accept_cmd(7'h12, 8'd3);
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL dnak_err_clear got=%0b exp=00", err); end
    respond(0, 0);
    respond(1, 0);
    feed(8'h11);
    respond(1, 0);
    feed(8'h22);
    checks++; if (byte_data !== 8'h22) begin errors++; $display("FAIL dnak_byte2 got=%0h exp=22", byte_data); end
    wr_valid = 1'b1; wr_data = 8'h33;
    respond(1, 1);
    checks++; if (stop_go !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL dnak_stop got=%0b/%0b exp=1/0", stop_go, wr_ready); end
    respond(2, 0);
    checks++; if (done !== 1'b1 || err !== 2'b10) begin errors++; $display("FAIL dnak_done got=%0b/%0b exp=1/10", done, err); end
    tick();
    wr_valid = 1'b0;
    checks++; if (accepted !== 2) begin errors++; $display("FAIL dnak_accepted got=%0d exp=2", accepted); end
  endtask

  task automatic test_first_cycle_ignored();
    accept_cmd(7'h05, 8'd0);
    start_done = 1'b1;
    tick();
    start_done = 1'b0;
    checks++; if (sel !== 2'b01 || byte_go !== 1'b0) begin errors++; $display("FAIL ign_start got=%0b/%0b exp=01/0", sel, byte_go); end
    respond(0, 0);
    checks++; if (byte_go !== 1'b1 || byte_data !== 8'h0A) begin errors++; $display("FAIL ign_addr got=%0b/%0h exp=1/0a", byte_go, byte_data); end
    respond(1, 0);
    respond(2, 0);
    checks++; if (done !== 1'b1 || err !== 2'b00) begin errors++; $display("FAIL ign_done got=%0b/%0b exp=1/00", done, err); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    accept_cmd(7'h10, 8'd0);
    n = 0;
    while (!stop_go && n < 40) begin tick(); n++; end
    checks++; if (n !== 15) begin errors++; $display("FAIL tmo_start_cycles got=%0d exp=15", n); end
    checks++; if (sel !== 2'b11 || err !== 2'b11) begin errors++; $display("FAIL tmo_start_stop got=%0b/%0b exp=11/11", sel, err); end
    respond(2, 0);
    checks++; if (done !== 1'b1 || err !== 2'b11) begin errors++; $display("FAIL tmo_start_done got=%0b/%0b exp=1/11", done, err); end
    tick();
    accept_cmd(7'h10, 8'd0);
    respond(0, 0);
    respond(1, 0);
    checks++; if (stop_go !== 1'b1 || err !== 2'b00) begin errors++; $display("FAIL tmo_stop_entry got=%0b/%0b exp=1/00", stop_go, err); end
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    checks++; if (n !== 15) begin errors++; $display("FAIL tmo_stop_cycles got=%0d exp=15", n); end
    checks++; if (done !== 1'b1 || sel !== 2'b00 || err !== 2'b11) begin errors++; $display("FAIL tmo_stop_done got=%0b/%0b/%0b exp=1/00/11", done, sel, err); end
    tick();
  endtask

  task automatic test_reset_mid_data();
    accept_cmd(7'h40, 8'd2);
    respond(0, 0);
    respond(1, 0);
    feed(8'h5A);
    tick();
    checks++; if (sel !== 2'b10 || busy !== 1'b1) begin errors++; $display("FAIL rmid_in_data got=%0b/%0b exp=10/1", sel, busy); end
    done_seen = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (sel !== 2'b00 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle got=%0b/%0b/%0b exp=00/0/1", sel, busy, cmd_ready); end
    checks++; if (stop_go !== 1'b0 || byte_data !== 8'h00) begin errors++; $display("FAIL rmid_outputs got=%0b/%0h exp=0/00", stop_go, byte_data); end
    tick(); tick(); tick();
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL rmid_no_done got=%0b exp=0", done_seen); end
    accept_cmd(7'h33, 8'd0);
    checks++; if (start_go !== 1'b1) begin errors++; $display("FAIL rmid_restart got=%0b exp=1", start_go); end
    respond(0, 0);
    checks++; if (byte_data !== 8'h66) begin errors++; $display("FAIL rmid_addr got=%0h exp=66", byte_data); end
    respond(1, 0);
    respond(2, 0);
    checks++; if (done !== 1'b1 || err !== 2'b00) begin errors++; $display("FAIL rmid_done got=%0b/%0b exp=1/00", done, err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_two();
    test_probe();
    test_addr_nack();
    test_data_nack();
    test_first_cycle_ignored();
    test_timeout();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/i2c_master_sequencer.md
Name: i2c_master_sequencer

Overview:
- Write-only I2C master transaction controller.
- Sequences the start generator, the byte engine (shift-out plus ACK sample) and the stop generator through one complete transaction: START, address+W, N data bytes, STOP.
- Arbitrates SCL/SDA ownership between those sub-blocks through a mux select.
- Sits between the host command/data stream and the I2C bit-level generators.

Parameters:
- TIMEOUT_CYCLES, 65535, max i_clk cycles to wait for any sub-block done before aborting; valid range 2..65535.
- LEN_W, 8, width of the byte-count field.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accept; high only in IDLE
- i_cmd_addr  in  7  7-bit target address
- i_cmd_len  in  LEN_W  number of data bytes; 0 = address-only probe
- i_wr_valid  in  1  write byte available
- o_wr_ready  out  1  write byte accept; high only in FETCH
- i_wr_data  in  8  write byte
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle transaction-complete pulse
- o_err  out  2  00 ok, 01 address NACK, 10 data NACK, 11 timeout; valid while o_done=1
- o_start_go  out  1  one-cycle start-generator trigger
- i_start_done  in  1  start generator finished
- o_byte_go  out  1  one-cycle byte-engine trigger
- o_byte_data  out  8  byte for the byte engine; held stable until i_byte_done
- i_byte_done  in  1  byte plus ACK slot finished
- i_byte_nack  in  1  ACK bit sampled high; qualified by i_byte_done
- o_stop_go  out  1  one-cycle stop-generator trigger
- i_stop_done  in  1  stop generator finished
- o_sel  out  2  bus owner: 00 released (SDA=SCL=1), 01 start gen, 10 byte engine, 11 stop gen

Behaviour:
- One clock. Reset is synchronous, active-low, and applies on the i_clk edge while i_rst_n=0.
- Reset state: IDLE. Reset output values: o_cmd_ready=1, o_wr_ready=0, o_busy=0, o_done=0, o_err=00, all *_go=0, o_byte_data=0, o_sel=00. Internal counters are cleared.
- Reset mid-transaction returns to IDLE immediately with o_sel=00. No STOP is issued.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Go pulses are high exactly in the first cycle of the waiting state. Done inputs are ignored in that cycle and sampled from the next cycle onward.

State machine:
- IDLE: on i_cmd_valid, latch addr and len into rem. Go to START.
- START: o_sel=01, o_start_go pulses. On i_start_done, o_byte_data={addr,1'b0}; go to ADDR.
- ADDR: o_sel=10, o_byte_go pulses.
  - On i_byte_done with nack: err=01, go to STOP.
  - On done without nack: if rem==0 go to STOP, else go to FETCH.
- FETCH: o_sel=10 (bus held, SCL low is legal stretching), o_wr_ready=1. No timeout in this state.
  - On i_wr_valid: o_byte_data=i_wr_data, rem=rem-1, go to DATA.
  - Handshake completes in the same cycle as valid&&ready.
- DATA: o_byte_go pulses.
  - On done with nack: err=10, go to STOP. Remaining bytes are not consumed.
  - On done without nack: if rem==0 go to STOP, else go to FETCH.
- STOP: o_sel=11, o_stop_go pulses. On i_stop_done, go to DONE.
- DONE: o_sel=00, o_done=1 for exactly one cycle with final o_err. Go to IDLE.
- o_err holds its value until the next command is accepted, then clears to 00.

Timeout:
- A 16-bit counter clears on every state entry and increments in START, ADDR, DATA and STOP.
- When count reaches TIMEOUT_CYCLES-1 without the expected done: err=11.
  - From START, ADDR or DATA: go to STOP.
  - From STOP: go to DONE directly, releasing the bus.
- If done and timeout occur in the same cycle, done wins.
- rem arithmetic is unsigned LEN_W. No decrement is performed when rem==0. Max length is 2^LEN_W-1.
- i_cmd_valid is ignored while busy. Done pulses that arrive in a state not waiting for them are ignored.

Test Plan:
- Command addr=0x50, len=2, data 0xA5,0x3C, all ACK:
  - start_go, then byte_go with 0xA0, 0xA5, 0x3C, then stop_go.
  - o_done with err=00.
  - o_wr_ready accepts exactly 2 bytes.
- Command addr=0x21, len=0: byte 0x42 sent, then STOP directly. o_wr_ready never asserted. err=00.
- Address NACK, addr=0x7F, len=3: 0xFE sent, i_byte_nack=1. STOP issued, err=01, zero write bytes consumed.
- Data NACK on the 2nd of 3 bytes: STOP after the 2nd byte, err=10. The third byte is not accepted.
- TIMEOUT_CYCLES=16, i_start_done never asserted: stop_go on START entry +15 cycles. Stop completes, then err=11.
  - Separately, i_stop_done withheld: DONE with o_sel=00, err=11.
- Reset held low 1 cycle in DATA: next cycle IDLE, o_sel=00, o_busy=0, no o_done. A new command is accepted normally afterwards.
